// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: branch codes, control-bit layout and EX/MEM squash FSM encoding.
package mips_pkg;

    localparam int unsigned BR_W   = 3;
    localparam int unsigned CTRL_W = 4;

    localparam int unsigned CTRL_REG_WRITE  = 3;
    localparam int unsigned CTRL_MEM_TO_REG = 2;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 0;

    typedef enum logic [BR_W-1:0] {
        BR_NONE   = 3'b000,
        BR_BEQ    = 3'b001,
        BR_BNE    = 3'b010,
        BR_BLEZ   = 3'b011,
        BR_BGTZ   = 3'b100,
        BR_ALWAYS = 3'b101
    } br_type_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: ID/EX-side inputs and EX/MEM pipeline-register outputs.
interface ex_mem_stage_if
    import mips_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned REG_ADDR = 5
) ();
    logic                i_valid;
    logic                o_ready;
    logic                i_mem_stall;
    logic [W-1:0]        i_alu_result;
    logic                i_zero;
    logic                i_neg;
    logic [BR_W-1:0]     i_branch_type;
    logic [W-1:0]        i_pc_plus4;
    logic [W-1:0]        i_imm;
    logic [W-1:0]        i_store_data;
    logic [REG_ADDR-1:0] i_rd;
    ctrl_t               i_ctrl;

    logic                o_valid;
    logic [W-1:0]        o_alu_result;
    logic [W-1:0]        o_store_data;
    logic [REG_ADDR-1:0] o_rd;
    ctrl_t               o_ctrl;
    logic                o_pc_src;
    logic [W-1:0]        o_branch_target;
    logic                o_flush;

    modport slave (
        input  i_valid, i_mem_stall, i_alu_result, i_zero, i_neg, i_branch_type,
               i_pc_plus4, i_imm, i_store_data, i_rd, i_ctrl,
        output o_ready, o_valid, o_alu_result, o_store_data, o_rd, o_ctrl,
               o_pc_src, o_branch_target, o_flush
    );

    modport master (
        output i_valid, i_mem_stall, i_alu_result, i_zero, i_neg, i_branch_type,
               i_pc_plus4, i_imm, i_store_data, i_rd, i_ctrl,
        input  o_ready, o_valid, o_alu_result, o_store_data, o_rd, o_ctrl,
               o_pc_src, o_branch_target, o_flush
    );
endinterface

// File: rtl/ex_mem_stage_branch_unit.sv
// Combinational branch resolution from ALU flags plus PC-relative target (wraps mod 2^W).
module branch_unit
    import mips_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [BR_W-1:0] i_branch_type,
    input  logic            i_zero,
    input  logic            i_neg,
    input  logic [W-1:0]    i_pc_plus4,
    input  logic [W-1:0]    i_imm,
    output logic            taken,
    output logic [W-1:0]    target
);

    always_comb begin
        taken = 1'b0;
        case (i_branch_type)
            BR_BEQ:    taken = i_zero;
            BR_BNE:    taken = ~i_zero;
            BR_BLEZ:   taken = i_neg | i_zero;
            BR_BGTZ:   taken = ~i_neg & ~i_zero;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    assign target = i_pc_plus4 + (i_imm << 2);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch redirect and one-instruction squash.
// Optional perf counters enabled by defining EX_MEM_PERF_EN.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned REG_ADDR = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    ex_mem_stage_if.slave bus
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0] o_retired_cnt,
    output logic [31:0] o_squashed_cnt
`endif
);

    localparam int unsigned CNT_W = 32;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [W-1:0]        alu_q, alu_d;
    logic [W-1:0]        store_q, store_d;
    logic [REG_ADDR-1:0] rd_q, rd_d;
    logic                pc_src_q, pc_src_d;
    logic [W-1:0]        target_q, target_d;

    logic                load;
    logic                accept;
    logic                taken;
    logic [W-1:0]        target;

    branch_unit #(.W(W)) u_branch_unit (
        .i_branch_type (bus.i_branch_type),
        .i_zero        (bus.i_zero),
        .i_neg         (bus.i_neg),
        .i_pc_plus4    (bus.i_pc_plus4),
        .i_imm         (bus.i_imm),
        .taken         (taken),
        .target        (target)
    );

    assign load   = ~bus.i_mem_stall;
    assign accept = load & bus.i_valid;

    // Next-state: stall holds everything except the redirect pulse, which always self-clears.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        alu_d    = alu_q;
        store_d  = store_q;
        rd_d     = rd_q;
        target_d = target_q;
        pc_src_d = 1'b0;

        if (load) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (bus.i_valid) begin
                alu_d   = bus.i_alu_result;
                store_d = bus.i_store_data;
                rd_d    = bus.i_rd;
                case (state_q)
                    ST_SQUASH: state_d = ST_RUN;
                    default: begin
                        valid_d = 1'b1;
                        ctrl_d  = bus.i_ctrl;
                        if (taken) begin
                            pc_src_d = 1'b1;
                            target_d = target;
                            state_d  = ST_SQUASH;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            alu_q    <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            pc_src_q <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            alu_q    <= alu_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            pc_src_q <= pc_src_d;
            target_q <= target_d;
        end
    end

    assign bus.o_ready         = ~bus.i_mem_stall;
    assign bus.o_valid         = valid_q;
    assign bus.o_ctrl          = ctrl_q;
    assign bus.o_alu_result    = alu_q;
    assign bus.o_store_data    = store_q;
    assign bus.o_rd            = rd_q;
    assign bus.o_pc_src        = pc_src_q;
    assign bus.o_flush         = pc_src_q;
    assign bus.o_branch_target = target_q;

`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] squashed_q, squashed_d;

    // Retired counts committed valid instructions; squashed counts killed ones.
    always_comb begin
        retired_d  = retired_q;
        squashed_d = squashed_q;
        if (accept) begin
            if (state_q == ST_SQUASH) squashed_d = squashed_q + CNT_W'(1);
            else                      retired_d  = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q  <= '0;
            squashed_q <= '0;
        end else begin
            retired_q  <= retired_d;
            squashed_q <= squashed_d;
        end
    end

    assign o_retired_cnt  = retired_q;
    assign o_squashed_cnt = squashed_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: driver pushes model expectations, monitor pops and compares.
module tb_ex_mem_stage;
    import mips_pkg::*;

    logic clk;
    logic rst_n;

    ex_mem_stage_if #(.W(32), .REG_ADDR(5)) bus ();

`ifdef EX_MEM_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] squashed_cnt;
`endif

    ex_mem_stage #(.W(32), .REG_ADDR(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef EX_MEM_PERF_EN
        ,
        .o_retired_cnt  (retired_cnt),
        .o_squashed_cnt (squashed_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        pc_src;
        logic [31:0] tgt;
        logic        ready;
        logic        all;
        logic [31:0] ret;
        logic [31:0] sq;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic sq_pend;
    logic [31:0] m_ret, m_sq;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic br_taken(input logic [2:0] br, input logic z, input logic n);
        case (br)
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n || z;
            3'd4:    return !n && !z;
            3'd5:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_idle();
        bus.i_valid = 1'b0; bus.i_mem_stall = 1'b0; bus.i_branch_type = 3'd0;
        bus.i_zero = 1'b0; bus.i_neg = 1'b0; bus.i_pc_plus4 = '0; bus.i_imm = '0;
        bus.i_alu_result = '0; bus.i_store_data = '0; bus.i_rd = '0; bus.i_ctrl = '0;
    endtask

    task automatic model_clear();
        cur = '{valid: 1'b0, ctrl: 4'd0, alu: 32'd0, sd: 32'd0, rd: 5'd0, pc_src: 1'b0,
                tgt: 32'd0, ready: 1'b1, all: 1'b0, ret: 32'd0, sq: 32'd0};
        sq_pend = 1'b0;
        m_ret = 32'd0;
        m_sq = 32'd0;
    endtask

    task automatic do_reset(input int cycles);
        exp_t e;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk); #1;
            rst_n = 1'b0;
            set_idle();
            model_clear();
            if (i == 0) begin
                #1;
                chk("async_rst_valid",  {31'd0, bus.o_valid}, 32'd0);
                chk("async_rst_pc_src", {31'd0, bus.o_pc_src}, 32'd0);
                chk("async_rst_flush",  {31'd0, bus.o_flush}, 32'd0);
                chk("async_rst_alu",    bus.o_alu_result, 32'd0);
            end
            e = cur;
            e.all = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic [2:0] br,
                         input logic z, input logic n, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input logic [3:0] ctrl);
        exp_t e;
        logic pulse;
        @(negedge clk); #1;
        rst_n = 1'b1;
        bus.i_valid = v; bus.i_mem_stall = st; bus.i_branch_type = br;
        bus.i_zero = z; bus.i_neg = n; bus.i_pc_plus4 = pc; bus.i_imm = imm;
        bus.i_alu_result = alu; bus.i_store_data = sd; bus.i_rd = rd; bus.i_ctrl = ctrl;
        pulse = 1'b0;
        if (!st) begin
            if (!v) begin
                cur.valid = 1'b0; cur.ctrl = 4'd0;
            end else if (sq_pend) begin
                cur.valid = 1'b0; cur.ctrl = 4'd0; sq_pend = 1'b0; m_sq = m_sq + 32'd1;
            end else begin
                cur.valid = 1'b1; cur.ctrl = ctrl; cur.alu = alu; cur.sd = sd; cur.rd = rd;
                m_ret = m_ret + 32'd1;
                if (br_taken(br, z, n)) begin
                    pulse = 1'b1;
                    cur.tgt = pc + imm * 32'd4;
                    sq_pend = 1'b1;
                end
            end
        end
        e = cur;
        e.pc_src = pulse;
        e.ready = !st;
        e.all = 1'b0;
        e.ret = m_ret;
        e.sq = m_sq;
        q.push_back(e);
    endtask

    task automatic instr(input logic [31:0] alu, input logic [4:0] rd, input logic [3:0] ctrl);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, alu, alu ^ 32'h5A5A_0000, rd, ctrl);
    endtask

    task automatic branch(input logic [2:0] br, input logic z, input logic n,
                          input logic [31:0] pc, input logic [31:0] imm);
        drive(1'b1, 1'b0, br, z, n, pc, imm, 32'hDEAD_0000 | {29'd0, br}, 32'h0, 5'd0, 4'd0);
    endtask

    task automatic idle(input logic st);
        drive(1'b0, st, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0);
    endtask

    // Monitor: compares every cycle's registered outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("o_valid",  {31'd0, bus.o_valid}, {31'd0, e.valid});
                chk("o_ctrl",   {28'd0, bus.o_ctrl}, {28'd0, e.ctrl});
                chk("o_pc_src", {31'd0, bus.o_pc_src}, {31'd0, e.pc_src});
                chk("o_flush",  {31'd0, bus.o_flush}, {31'd0, e.pc_src});
                chk("o_ready",  {31'd0, bus.o_ready}, {31'd0, e.ready});
                if (e.valid || e.all) begin
                    chk("o_alu_result", bus.o_alu_result, e.alu);
                    chk("o_store_data", bus.o_store_data, e.sd);
                    chk("o_rd",         {27'd0, bus.o_rd}, {27'd0, e.rd});
                end
                if (e.pc_src || e.all)
                    chk("o_branch_target", bus.o_branch_target, e.tgt);
`ifdef EX_MEM_PERF_EN
                chk("o_retired_cnt",  retired_cnt, e.ret);
                chk("o_squashed_cnt", squashed_cnt, e.sq);
`endif
            end
        end
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        set_idle();
        model_clear();
        do_reset(2);

        // Five-instruction stream with one taken branch (retired 4, squashed 1).
        instr(32'h0000_0007, 5'd3, 4'b1000);
        branch(3'd1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0004);
        instr(32'h0000_1111, 5'd4, 4'b1000);
        instr(32'h0000_2222, 5'd5, 4'b1100);
        instr(32'h0000_3333, 5'd6, 4'b0001);

        // Not-taken branches pass straight through.
        branch(3'd2, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0010);
        branch(3'd4, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0010);
        instr(32'h0000_4444, 5'd7, 4'b1010);

        // Stall right after a taken branch: single pulse, hold, squash after stall.
        branch(3'd3, 1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_5555, 32'h1, 5'd8, 4'b1000);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_5555, 32'h1, 5'd8, 4'b1000);
        instr(32'h0000_6666, 5'd9, 4'b1000);

        // Taken branch followed by a taken branch: second one is squashed.
        branch(3'd5, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0020);
        branch(3'd1, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_0020);
        instr(32'h0000_7777, 5'd10, 4'b1000);

        // Bubbles while squash pending keep the squash armed; target wraps.
        branch(3'd5, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0008);
        idle(1'b0);
        idle(1'b0);
        instr(32'h0000_8888, 5'd11, 4'b1000);
        instr(32'h0000_9999, 5'd12, 4'b1000);

        // Reset while the redirect pulse is high and a squash is pending.
        branch(3'd5, 1'b0, 1'b0, 32'h0000_0700, 32'h0000_0001);
        do_reset(2);
        instr(32'h0000_0007, 5'd3, 4'b1000);
        instr(32'h0000_abcd, 5'd13, 4'b0100);

        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FFFC, {{16{r[15]}}, r[15:0]},
                  $urandom, $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 3; i++) idle(1'b0);
        @(negedge clk); #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage of the MIPS core, directly downstream of the ALU. It registers the ALU result, store data, destination register and memory/writeback controls into the EX/MEM pipeline register. It resolves conditional branches from the ALU's `zero_flag`/`neg_flag`, issues a one-cycle PC redirect and front-end flush, and squashes the one younger instruction already in flight. It also honours back-pressure from the memory stage.

## Interface
Parameters:
- `W`, 32: datapath width; ALU result, PC and immediate width.
- `REG_ADDR`, 5: register-file address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  ID/EX holds a valid instruction.
- `o_ready`  out  1  stage accepts this cycle; `o_ready = ~i_mem_stall`, combinational.
- `i_mem_stall`  in  1  memory stage cannot take a new instruction.
- `i_alu_result`  in  W  ALU `RESULT_OUT`.
- `i_zero`  in  1  ALU `zero_flag`; valid only for the subtract opcode.
- `i_neg`  in  1  ALU `neg_flag`; MSB of A−B, with no overflow correction.
- `i_branch_type`  in  3  branch type: 000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 B (always); 110/111 treated as none.
- `i_pc_plus4`  in  W  PC+4 of the instruction.
- `i_imm`  in  W  sign-extended word offset.
- `i_store_data`  in  W  rt value for SW.
- `i_rd`  in  REG_ADDR  destination register.
- `i_ctrl`  in  4  control bits {reg_write, mem_to_reg, mem_read, mem_write}.
- `o_valid`  out  1  EX/MEM holds a valid instruction.
- `o_alu_result`, `o_store_data`  out  W  registered copies of the inputs.
- `o_rd`  out  REG_ADDR  registered destination.
- `o_ctrl`  out  4  registered control bits; forced to 0 when `o_valid`=0.
- `o_pc_src`  out  1  one-cycle pulse: fetch must load `o_branch_target`.
- `o_branch_target`  out  W  registered branch target.
- `o_flush`  out  1  one-cycle pulse, coincident with `o_pc_src`: kill the IF/ID contents.

## Operation
Acceptance:
- An instruction is accepted on an edge where `i_valid & o_ready`.
- On acceptance, all EX/MEM fields load.
- If `i_valid`=0 while `o_ready`=1, the stage loads a bubble: `o_valid`=0, `o_ctrl`=0.

Branch condition (`taken`), evaluated on the accepted instruction:
- BEQ: `i_zero`.
- BNE: `~i_zero`.
- BLEZ: `i_neg | i_zero`.
- BGTZ: `~i_neg & ~i_zero`.
- B: 1.
- none: 0.

Branch target and redirect:
- Target = `i_pc_plus4 + (i_imm << 2)`, computed modulo 2^W; wrap-around is silent.
- There is no delay slot.

Squash FSM (2 states):
- RUN: accepting a taken branch sets `o_pc_src`=`o_flush`=1 for the next cycle and moves the FSM to SQUASH.
- SQUASH: the next accepted instruction loads as a bubble (`o_valid`=0, `o_ctrl`=0), then the FSM returns to RUN.
- SQUASH with no accepted instruction: stay in SQUASH.
- A squashed instruction never redirects, even if it is a taken branch.

A taken branch itself commits with `o_valid`=1 and whatever `i_ctrl` it carries (normally 0).

## Timing
- Latency: 1 cycle from the acceptance edge to the registered outputs.
- Stall (`i_mem_stall`=1): all EX/MEM registers and the FSM hold. `o_pc_src`/`o_flush` still deassert after their single cycle; the pulse is never stretched or repeated.
- `o_pc_src`/`o_flush` are high exactly one cycle per taken branch and never in two consecutive cycles.
- Reset (async, any time, including mid-stall or in SQUASH):
  - All outputs go to 0 immediately; FSM goes to RUN.
  - Any pending squash is discarded.
  - The first edge after deassertion behaves as RUN.

## Configuration
- `EX_MEM_PERF_EN` defined:
  - Adds `o_retired_cnt` and `o_squashed_cnt`, both out, 32 bits, reset to 0.
  - `o_retired_cnt` increments on each accepted non-squashed valid instruction.
  - `o_squashed_cnt` increments on each squash.
  - Both wrap silently at 2^32.
- `EX_MEM_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - branch-type codes (`BR_NONE` … `BR_ALWAYS`);
  - `i_ctrl` bit indices;
  - the FSM state encoding (`ST_RUN`, `ST_SQUASH`).
- One combinational sub-module, `branch_unit`: inputs `i_branch_type`, `i_zero`, `i_neg`, `i_pc_plus4`, `i_imm`; outputs `taken` and `target`.
- The pipeline register, FSM and perf counters stay in `ex_mem_stage`.

## Test plan
- Reset: hold `rst_n`=0 mid-stream -> all outputs 0 asynchronously; release -> first valid ALU add (result 0x0000_0007, rd=3, ctrl=1000) appears on the outputs one cycle after acceptance.
- BEQ taken: zero=1, pc_plus4=0x100, imm=0x4 -> next cycle `o_pc_src`=`o_flush`=1, `o_branch_target`=0x110. The following accepted instruction has `o_valid`=0, `o_ctrl`=0. The next one commits.
- BNE not taken (zero=1) and BGTZ with neg=1 -> no pulse, no squash, outputs pass through.
- Stall: `i_mem_stall`=1 for 3 cycles right after a taken branch -> the pulse lasts 1 cycle only; registers hold; squash applies to the first instruction accepted after the stall.
- Squashed taken branch: B immediately followed by BEQ (zero=1) -> exactly one redirect pulse.
- With `EX_MEM_PERF_EN`: stream of 5 instructions containing one taken branch -> `o_retired_cnt`=4, `o_squashed_cnt`=1.
